// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl
//
// Scan sequencer for a 2-to-4 line decoder. After a start request it steps through
// the slots enabled in mask in ascending order. Each slot lasts DIV clock cycles.
// One pass over the enabled slots is a sweep. The block either sweeps continuously
// (mode=0) or performs one sweep and then returns to idle (mode=1).
//
// Parameters
//   DIV   slot length in clk cycles (2..65535)
//   GAP   enable-off cycles at the start of each slot (1..DIV-1); only used when
//         SCAN_GAP_EN is defined
//
// Ports
//   clk    in   clock; all state changes on its rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   begin scanning when idle (needs at least one mask bit set)
//   stop   in   abort scanning and return to idle; takes priority over everything
//   mode   in   0 = continuous sweeps, 1 = single sweep then idle
//   mask   in   [3:0] slot enables; bit i = slot i participates
//   blank  in   forces e low combinationally; sequencing is unaffected
//   a0,a1  out  selected slot index {a1,a0}; holds its last value while idle
//   e      out  decoder enable (combinational)
//   busy   out  high while scanning
//   done   out  one-cycle pulse coinciding with the slot that follows a sweep end
//
// Configuration macro
//   SCAN_GAP_EN  when defined, e is held low for the first GAP cycles of every slot
//                so the address settles before the decoder is enabled (anti-ghosting).

module decoder_scan_ctrl #(
    parameter int unsigned DIV = 4,
    parameter int unsigned GAP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       mode,
    input  logic [3:0] mask,
    input  logic       blank,
    output logic       a0,
    output logic       a1,
    output logic       e,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    // Elaboration-time guard on the parameter ranges.
    if (DIV < 2 || DIV > 65535) begin : g_bad_div
        $error("decoder_scan_ctrl: DIV out of range");
    end
    if (GAP < 1 || GAP >= DIV) begin : g_bad_gap
        $error("decoder_scan_ctrl: GAP out of range");
    end

    typedef enum logic {
        StIdle,
        StActive
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]    addr_q, addr_d;
    logic          done_q, done_d;

    logic [1:0]    first_idx;
    logic [1:0]    next_idx;
    logic [1:0]    cand;
    logic          found;
    logic          wrap;
    logic          gap_window;

    // Lowest enabled slot, used when a scan begins.
    always_comb begin
        first_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) begin
                first_idx = 2'(i);
            end
        end
    end

    // Next enabled slot after the current one, searching upward with wrap 3->0.
    // The last candidate (k=4) is the current slot itself, which covers the
    // single-bit mask case.
    always_comb begin
        next_idx = addr_q;
        found    = 1'b0;
        cand     = addr_q;
        for (int k = 1; k <= 4; k++) begin
            cand = addr_q + 2'(k);
            if (!found && mask[cand]) begin
                next_idx = cand;
                found    = 1'b1;
            end
        end
    end

    // Moving to an index not above the current one closes a sweep.
    assign wrap = (next_idx <= addr_q);

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        addr_d    = addr_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !stop && (mask != 4'b0000)) begin
                    state_d   = StActive;
                    addr_d    = first_idx;
                    div_cnt_d = '0;
                end
            end
            StActive: begin
                if (stop) begin
                    // Abort wins over a coincident boundary; no done pulse.
                    state_d   = StIdle;
                    div_cnt_d = '0;
                end else if (div_cnt_q == CNT_MAX) begin
                    div_cnt_d = '0;
                    if (mask == 4'b0000) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else if (wrap) begin
                        done_d = 1'b1;
                        if (mode) begin
                            // Single sweep finished: keep showing the final slot.
                            state_d = StIdle;
                        end else begin
                            addr_d = next_idx;
                        end
                    end else begin
                        addr_d = next_idx;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            div_cnt_q <= '0;
            addr_q    <= 2'b00;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
        end
    end

`ifdef SCAN_GAP_EN
    localparam logic [CW-1:0] GAP_CNT = CW'(GAP);
    assign gap_window = (div_cnt_q < GAP_CNT);
`else
    assign gap_window = 1'b0;
`endif

    assign a0   = addr_q[0];
    assign a1   = addr_q[1];
    assign busy = (state_q == StActive);
    assign done = done_q;
    assign e    = (state_q == StActive) && !blank && !gap_window;

endmodule

// File: doc/decoder_scan_ctrl.md
DECODER_SCAN_CTRL -- requirements
Module: decoder_scan_ctrl

Interface
REQ-001 Parameter DIV, default 4, slot length in clk cycles; legal range 2..65535.
REQ-002 Parameter GAP, default 1, enable-off cycles at slot start when SCAN_GAP_EN is defined; legal range 1..DIV-1.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin scanning when IDLE.
REQ-006 stop  input  1  abort scanning; return to IDLE.
REQ-007 mode  input  1  0 = continuous sweeps; 1 = single sweep, then IDLE.
REQ-008 mask  input  4  slot enable, bit i = slot i participates.
REQ-009 blank  input  1  forces e low combinationally; sequencing continues.
REQ-010 a0, a1  output  1 each  selected slot index {a1,a0}, drives the 2-to-4 decoder address.
REQ-011 e  output  1  decoder enable.
REQ-012 busy  output  1  high while not IDLE.
REQ-013 done  output  1  one-cycle pulse at end of sweep.

Function
REQ-014 States: IDLE and ACTIVE; slot counter div_cnt has width ceil(log2(DIV)).
REQ-015 IDLE: e=0, busy=0, {a1,a0} holds last value.
REQ-016 IDLE with start=1, stop=0, mask!=0 at edge k: from edge k, state=ACTIVE, busy=1, {a1,a0}=lowest set mask index, div_cnt=0.
REQ-017 IDLE with start=1 and mask=0: start ignored; no state change, no done.
REQ-018 ACTIVE: div_cnt increments each cycle.
REQ-019 At div_cnt=DIV-1: div_cnt returns to 0 and {a1,a0} advances to the next set mask bit in ascending order, wrapping 3->0; mask is sampled at that edge.
REQ-020 Sweep end: an advance that wraps (next index <= current index) pulses done for exactly one cycle, coincident with the new slot.
REQ-021 At sweep end with mode=1: state goes to IDLE instead of advancing; done pulses; {a1,a0} keeps the final slot.
REQ-022 Only one mask bit set: slot stays selected; each boundary counts as sweep end.
REQ-023 Mask becomes 0 while ACTIVE: at the next boundary, state goes to IDLE and done pulses.
REQ-024 stop=1 while ACTIVE: next edge to IDLE; done stays 0; stop overrides a coincident boundary or sweep end.
REQ-025 start and stop both high in IDLE: stop wins; remain IDLE.
REQ-026 start while ACTIVE is ignored; the counter is not restarted.
REQ-027 e = (state=ACTIVE) AND NOT blank AND NOT gap_window; all other outputs are registered.

Reset
REQ-028 On rst_n low, asynchronously: state=IDLE, {a1,a0}=00, div_cnt=0, e=0, busy=0, done=0.
REQ-029 Reset mid-sweep discards progress; after release the block waits for a new start.
REQ-030 First edge after rst_n rises obeys REQ-016 normally.

Configuration
REQ-031 Macro SCAN_GAP_EN: defined -> gap_window is active when div_cnt < GAP, giving GAP cycles of e=0 at the start of every slot (anti-ghosting) while {a1,a0} already shows the new slot.
REQ-032 SCAN_GAP_EN undefined -> gap_window=0; GAP is unused; e stays high for the whole slot.

Verification (DIV=4, GAP=1)
REQ-033 mask=1111, mode=0, start pulse, no macro -> {a1,a0} = 0,1,2,3,0 for 4 cycles each; e=1 throughout; done pulses once at the 3->0 wrap.
REQ-034 mask=1010, mode=1 -> slot 1 for 4 cycles, then slot 3 for 4 cycles; done pulses 1 cycle; busy=0 and e=0 afterwards; {a1,a0}=11.
REQ-035 Continuous scan, stop asserted at div_cnt=3 of slot 3 -> IDLE next edge; done=0; e=0.
REQ-036 rst_n low at slot 2 mid-cycle -> immediately e=0, {a1,a0}=00, busy=0; start after release restarts from the lowest enabled slot.
REQ-037 SCAN_GAP_EN defined, mask=0011 -> each 4-cycle slot shows e pattern 0,1,1,1.
REQ-038 blank=1 for 2 cycles mid-slot -> e=0 in those cycles only; slot timing and done timing unchanged.
